// File: rtl/game_input_frontend.sv
// Input conditioning for the mini-game: synchronises and debounces the two active-low
// buttons into press pulses, and debounces the slide switches against a captured snapshot.
module game_input_frontend #(
    parameter int SW_WIDTH  = 10,
    parameter int DB_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn0,
    input  logic                btn1,
    input  logic [SW_WIDTH-1:0] switch,
    input  logic                snap,
    output logic                enter_pulse,
    output logic                reset_pulse,
    output logic                enter_held,
    output logic                ready,
    output logic [SW_WIDTH-1:0] sw_clean,
    output logic [SW_WIDTH-1:0] sw_changes,
    output logic                sw_any,
    output logic                sw_single
);

    localparam int               CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        BTN_RELEASED,
        BTN_PRESS_CHK,
        BTN_HELD,
        BTN_REL_CHK
    } btn_state_e;

    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic [1:0] btn_held;

    assign btn_raw = {btn1, btn0};

    // Index 0 is the enter button, index 1 the reset button; both are fully independent.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            btn_state_e       state_q;
            btn_state_e       state_d;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             pulse_q;
            logic             pulse_d;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    state_q <= BTN_RELEASED;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pulse_q <= pulse_d;
                end
            end

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                pulse_d = 1'b0;
                case (state_q)
                    BTN_RELEASED: begin
                        if (!sync2_q) begin
                            state_d = BTN_PRESS_CHK;
                            cnt_d   = '0;
                        end
                    end
                    BTN_PRESS_CHK: begin
                        if (sync2_q) begin
                            state_d = BTN_RELEASED;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = BTN_HELD;
                            pulse_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    BTN_HELD: begin
                        if (sync2_q) begin
                            state_d = BTN_REL_CHK;
                            cnt_d   = '0;
                        end
                    end
                    BTN_REL_CHK: begin
                        if (!sync2_q) begin
                            state_d = BTN_HELD;
                        end else if (cnt_q == CNT_MAX) begin
                            state_d = BTN_RELEASED;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: state_d = BTN_RELEASED;
                endcase
            end

            assign btn_pulse[gi] = pulse_q;
            assign btn_held[gi]  = (state_q == BTN_HELD) || (state_q == BTN_REL_CHK);
        end
    endgenerate

    assign enter_pulse = btn_pulse[0];
    assign reset_pulse = btn_pulse[1];
    assign enter_held  = btn_held[0];

    logic [SW_WIDTH-1:0] sw_sync1_q;
    logic [SW_WIDTH-1:0] sw_sync2_q;
    logic [SW_WIDTH-1:0] cand_q;
    logic [SW_WIDTH-1:0] cand_d;
    logic [CNT_W-1:0]    sw_cnt_q;
    logic [CNT_W-1:0]    sw_cnt_d;
    logic [SW_WIDTH-1:0] clean_q;
    logic [SW_WIDTH-1:0] clean_d;
    logic [SW_WIDTH-1:0] snapshot_q;
    logic [SW_WIDTH-1:0] snapshot_d;
    logic                ready_q;
    logic                ready_d;
    logic [SW_WIDTH-1:0] changes_q;
    logic [SW_WIDTH-1:0] changes_d;
    logic                any_q;
    logic                any_d;
    logic                single_q;
    logic                single_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            cand_q     <= '0;
            sw_cnt_q   <= '0;
            clean_q    <= '0;
            snapshot_q <= '0;
            ready_q    <= 1'b0;
            changes_q  <= '0;
            any_q      <= 1'b0;
            single_q   <= 1'b0;
        end else begin
            sw_sync1_q <= switch;
            sw_sync2_q <= sw_sync1_q;
            cand_q     <= cand_d;
            sw_cnt_q   <= sw_cnt_d;
            clean_q    <= clean_d;
            snapshot_q <= snapshot_d;
            ready_q    <= ready_d;
            changes_q  <= changes_d;
            any_q      <= any_d;
            single_q   <= single_d;
        end
    end

    // One settle counter for the whole bank: any bit moving restarts settling for all of them.
    always_comb begin
        cand_d     = cand_q;
        sw_cnt_d   = sw_cnt_q;
        clean_d    = clean_q;
        snapshot_d = snapshot_q;
        ready_d    = ready_q;
        if (cand_q != sw_sync2_q) begin
            cand_d   = sw_sync2_q;
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CNT_MAX) begin
            clean_d = cand_q;
            if (!ready_q) begin
                snapshot_d = cand_q;
                ready_d    = 1'b1;
            end
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
        // Capture the value sw_clean is taking this edge, so a coincident settle is not missed.
        if (snap && ready_q) begin
            snapshot_d = clean_d;
        end
    end

    always_comb begin
        changes_d = clean_q ^ snapshot_q;
        any_d     = |changes_d;
        single_d  = any_d && ((changes_d & (changes_d - SW_WIDTH'(1))) == '0);
    end

    assign ready      = ready_q;
    assign sw_clean   = clean_q;
    assign sw_changes = changes_q;
    assign sw_any     = any_q;
    assign sw_single  = single_q;

endmodule

// File: tb/tb_game_input_frontend.sv
// Directed bench for game_input_frontend with DB_CYCLES=4: edge-exact pulse, held and switch checks.
module tb_game_input_frontend;

    localparam int SW_WIDTH = 10;

    logic                clk;
    logic                rst_n;
    logic                btn0;
    logic                btn1;
    logic [SW_WIDTH-1:0] switch;
    logic                snap;
    logic                enter_pulse;
    logic                reset_pulse;
    logic                enter_held;
    logic                ready;
    logic [SW_WIDTH-1:0] sw_clean;
    logic [SW_WIDTH-1:0] sw_changes;
    logic                sw_any;
    logic                sw_single;

    int n_checks = 0;
    int n_pass   = 0;

    game_input_frontend #(
        .SW_WIDTH (SW_WIDTH),
        .DB_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn0       (btn0),
        .btn1       (btn1),
        .switch     (switch),
        .snap       (snap),
        .enter_pulse(enter_pulse),
        .reset_pulse(reset_pulse),
        .enter_held (enter_held),
        .ready      (ready),
        .sw_clean   (sw_clean),
        .sw_changes (sw_changes),
        .sw_any     (sw_any),
        .sw_single  (sw_single)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " enter_pulse"}, 32'(enter_pulse), 32'd0);
        check_val({tag, " reset_pulse"}, 32'(reset_pulse), 32'd0);
        check_val({tag, " enter_held"},  32'(enter_held),  32'd0);
        check_val({tag, " ready"},       32'(ready),       32'd0);
        check_val({tag, " sw_clean"},    32'(sw_clean),    32'd0);
        check_val({tag, " sw_changes"},  32'(sw_changes),  32'd0);
        check_val({tag, " sw_any"},      32'(sw_any),      32'd0);
        check_val({tag, " sw_single"},   32'(sw_single),   32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        btn0   = 1'b1;
        btn1   = 1'b1;
        switch = 10'h008;
        snap   = 1'b0;

        // 1. reset state and initial switch settle
        repeat (3) tick();
        check_all_zero("reset");
        $display("txn reset: outputs held at zero");
        rst_n = 1'b1;
        repeat (6) tick();
        check_val("init ready e6", 32'(ready), 32'd0);
        tick();
        check_val("init ready e7", 32'(ready), 32'd1);
        check_val("init sw_clean e7", 32'(sw_clean), 32'h008);
        tick();
        check_val("init sw_changes", 32'(sw_changes), 32'd0);
        check_val("init sw_any", 32'(sw_any), 32'd0);
        $display("txn init: ready with sw_clean=0x%0h", sw_clean);

        // 2. clean press held for 20 cycles, then release
        btn0 = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_val($sformatf("press pulse e%0d", e), 32'(enter_pulse), 32'(e == 7));
            check_val($sformatf("press held e%0d", e), 32'(enter_held), 32'(e >= 7));
            check_val($sformatf("press rpulse e%0d", e), 32'(reset_pulse), 32'd0);
        end
        btn0 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val($sformatf("release held e%0d", e), 32'(enter_held), 32'(e < 7));
            check_val($sformatf("release pulse e%0d", e), 32'(enter_pulse), 32'd0);
        end
        $display("txn press/release: btn0 pulse at edge 7, held dropped at edge 7");

        // 3a. bounce: low 3, high 1, then low stable
        for (int e = 1; e <= 16; e++) begin
            btn0 = (e == 4) ? 1'b1 : 1'b0;
            tick();
            check_val($sformatf("bounce pulse e%0d", e), 32'(enter_pulse), 32'(e == 11));
        end
        btn0 = 1'b1;
        repeat (10) tick();
        check_val("bounce released", 32'(enter_held), 32'd0);
        $display("txn bounce: single pulse 7 edges after final fall");

        // 3b. lone 3-cycle glitch
        for (int e = 1; e <= 12; e++) begin
            btn0 = (e <= 3) ? 1'b0 : 1'b1;
            tick();
            check_val($sformatf("glitch pulse e%0d", e), 32'(enter_pulse), 32'd0);
            check_val($sformatf("glitch held e%0d", e), 32'(enter_held), 32'd0);
        end
        $display("txn glitch: rejected");

        // 4. switch changes against the init snapshot (0x008)
        switch = 10'h000;
        repeat (10) tick();
        check_val("sw1 clean", 32'(sw_clean), 32'h000);
        check_val("sw1 changes", 32'(sw_changes), 32'h008);
        check_val("sw1 single", 32'(sw_single), 32'd1);
        check_val("sw1 any", 32'(sw_any), 32'd1);
        $display("txn switch[3] flip: changes=0x%0h", sw_changes);
        switch = 10'h020;
        repeat (10) tick();
        check_val("sw2 clean", 32'(sw_clean), 32'h020);
        check_val("sw2 changes", 32'(sw_changes), 32'h028);
        check_val("sw2 single", 32'(sw_single), 32'd0);
        check_val("sw2 any", 32'(sw_any), 32'd1);
        $display("txn switch[5] flip: changes=0x%0h", sw_changes);

        // 5. snapshot capture: changes clear one edge after the snapshot edge
        snap = 1'b1;
        tick();
        snap = 1'b0;
        check_val("snap changes same edge", 32'(sw_changes), 32'h028);
        tick();
        check_val("snap changes next", 32'(sw_changes), 32'h000);
        check_val("snap any next", 32'(sw_any), 32'd0);
        check_val("snap single next", 32'(sw_single), 32'd0);
        check_val("snap clean kept", 32'(sw_clean), 32'h020);
        $display("txn snap: changes cleared");

        // 6. simultaneous presses, then reset while held
        btn0 = 1'b0;
        btn1 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check_val($sformatf("dual enter e%0d", e), 32'(enter_pulse), 32'(e == 7));
            check_val($sformatf("dual reset e%0d", e), 32'(reset_pulse), 32'(e == 7));
        end
        $display("txn dual press: both pulses at edge 7");
        repeat (3) tick();
        check_val("pre-rst held", 32'(enter_held), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        $display("txn async reset while held: outputs cleared");
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val($sformatf("rearm enter e%0d", e), 32'(enter_pulse), 32'(e == 7));
            check_val($sformatf("rearm reset e%0d", e), 32'(reset_pulse), 32'(e == 7));
            check_val($sformatf("rearm ready e%0d", e), 32'(ready), 32'(e >= 7));
        end
        check_val("rearm sw_clean", 32'(sw_clean), 32'h020);
        check_val("rearm sw_changes", 32'(sw_changes), 32'h000);
        check_val("rearm held", 32'(enter_held), 32'd1);
        $display("txn held through reset: one new pulse at edge 7");

        btn0 = 1'b1;
        btn1 = 1'b1;
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
